tx_packet_scheduler: RTL

Sequences one video frame's worth of Ethernet packets on the 125 MHz transmit side. It sits between the HDMI capture (`start_frame`), the packet builder (`byte_data`) and the frame memory (`tx_memory_control`). Each segment is sent `redundancy` times, with an inter-packet gap scaled to the negotiated link speed. It drives the segment number, copy index and frame id that the builder and memory use, and reports frame completion.

---
 rtl/tx_packet_scheduler_if.sv | 33 +++
 rtl/tx_packet_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tx_packet_scheduler_if.sv
// tx_packet_scheduler_if
// Packet-launch handshake between the transmit scheduler and the packet
// builder (byte_data) / frame memory.
//   start_sending : one-cycle launch pulse, scheduler -> builder
//   busy          : builder is sending a packet, builder -> scheduler
//   segment_num   : current segment index, scheduler -> builder/memory
//   aux           : current copy index 0..R-1, scheduler -> builder/memory
//   txid          : frame id, scheduler -> builder/memory
interface tx_packet_scheduler_if #(
    parameter int unsigned SEG_W = 16
);
    logic             start_sending;
    logic             busy;
    logic [SEG_W-1:0] segment_num;
    logic [7:0]       aux;
    logic [7:0]       txid;

    modport master (
        output start_sending,
        output segment_num,
        output aux,
        output txid,
        input  busy
    );

    modport slave (
        input  start_sending,
        input  segment_num,
        input  aux,
        input  txid,
        output busy
    );
endinterface

// File: rtl/tx_packet_scheduler.sv
// tx_packet_scheduler
// Sequences one video frame of Ethernet packets on the 125 MHz transmit
// side: every segment 0..M is launched R times, with an inter-packet gap
// scaled to the link speed, then frame completion is reported.
// Ports:
//   clk125MHz       : clock, rising edge
//   rst             : asynchronous active-high reset
//   enable          : scheduler enable; aborts a frame in GAP/ADVANCE
//   start_frame     : one-cycle pulse per captured frame
//   segment_num_max : index of the last segment (latched at frame start)
//   redundancy      : copies per segment, 0 treated as 1 (latched)
//   speed           : 11=1000, 10=100, 01=10, 00=no link
//   tx              : launch handshake / segment, copy, frame id (master)
//   oneframe_done   : one-cycle pulse after the last packet of a frame
//   sched_active    : high whenever the FSM is not IDLE
//   timeout_err     : sticky, builder never raised busy after a launch
//   frames_dropped  : saturating count of start_frame pulses while busy
module tx_packet_scheduler #(
    parameter int unsigned SEG_W        = 16,
    parameter int unsigned GAP_CYCLES   = 12,
    parameter int unsigned BUSY_TIMEOUT = 255
) (
    input  logic                   clk125MHz,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   start_frame,
    input  logic [SEG_W-1:0]       segment_num_max,
    input  logic [7:0]             redundancy,
    input  logic [1:0]             speed,
    tx_packet_scheduler_if.master  tx,
    output logic                   oneframe_done,
    output logic                   sched_active,
    output logic                   timeout_err,
    output logic [7:0]             frames_dropped
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_HI,
        WAIT_LO,
        GAP,
        ADVANCE,
        DONE
    } state_t;

    localparam logic [15:0] GAP_1000 = 16'(GAP_CYCLES);
    localparam logic [15:0] GAP_100  = 16'(GAP_CYCLES * 10);
    localparam logic [15:0] GAP_10   = 16'(GAP_CYCLES * 100);
    localparam logic [15:0] TO_LAST  = 16'(BUSY_TIMEOUT - 1);

    state_t           state_q;
    logic             start_sending_q;
    logic             oneframe_done_q;
    logic             timeout_err_q;
    logic [7:0]       frames_dropped_q;
    logic [SEG_W-1:0] seg_q;
    logic [SEG_W-1:0] seg_max_q;
    logic [7:0]       aux_q;
    logic [7:0]       red_q;
    logic [7:0]       txid_q;
    logic [15:0]      wait_cnt_q;
    logic [15:0]      gap_cnt_q;
    logic [15:0]      gap_len_q;
    logic [15:0]      gap_len_d;
    logic             gap_last;

    // Gap length is sampled on GAP entry, so a speed change mid-frame only
    // affects the next gap. With no link the slowest gap is used.
    always_comb begin
        gap_len_d = GAP_10;
        case (speed)
            2'b11:   gap_len_d = GAP_1000;
            2'b10:   gap_len_d = GAP_100;
            default: gap_len_d = GAP_10;
        endcase
    end

    assign gap_last = ({1'b0, gap_cnt_q} + 17'd1) >= {1'b0, gap_len_q};

    always_ff @(posedge clk125MHz or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            start_sending_q  <= 1'b0;
            oneframe_done_q  <= 1'b0;
            timeout_err_q    <= 1'b0;
            frames_dropped_q <= '0;
            seg_q            <= '0;
            seg_max_q        <= '0;
            aux_q            <= '0;
            red_q            <= 8'd1;
            txid_q           <= '0;
            wait_cnt_q       <= '0;
            gap_cnt_q        <= '0;
            gap_len_q        <= '0;
        end else begin
            start_sending_q <= 1'b0;
            oneframe_done_q <= 1'b0;

            if (start_frame && (state_q != IDLE) && (frames_dropped_q != 8'hFF))
                frames_dropped_q <= frames_dropped_q + 8'd1;

            case (state_q)
                IDLE: begin
                    if (start_frame && enable && (speed != 2'b00)) begin
                        seg_max_q       <= segment_num_max;
                        red_q           <= (redundancy == 8'd0) ? 8'd1 : redundancy;
                        seg_q           <= '0;
                        aux_q           <= '0;
                        start_sending_q <= 1'b1;
                        state_q         <= LAUNCH;
                    end
                end

                LAUNCH: begin
                    // The launch cycle itself counts toward the busy timeout.
                    wait_cnt_q <= 16'd1;
                    state_q    <= WAIT_HI;
                end

                WAIT_HI: begin
                    if (tx.busy) begin
                        state_q <= WAIT_LO;
                    end else if (wait_cnt_q >= TO_LAST) begin
                        timeout_err_q <= 1'b1;
                        gap_cnt_q     <= '0;
                        gap_len_q     <= gap_len_d;
                        state_q       <= GAP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end

                WAIT_LO: begin
                    if (!tx.busy) begin
                        gap_cnt_q <= '0;
                        gap_len_q <= gap_len_d;
                        state_q   <= GAP;
                    end
                end

                GAP: begin
                    if (!enable)
                        state_q <= IDLE;
                    else if (gap_last)
                        state_q <= ADVANCE;
                    else
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                end

                ADVANCE: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (aux_q < (red_q - 8'd1)) begin
                        aux_q           <= aux_q + 8'd1;
                        start_sending_q <= 1'b1;
                        state_q         <= LAUNCH;
                    end else if (seg_q < seg_max_q) begin
                        seg_q           <= seg_q + 1'b1;
                        aux_q           <= '0;
                        start_sending_q <= 1'b1;
                        state_q         <= LAUNCH;
                    end else begin
                        oneframe_done_q <= 1'b1;
                        state_q         <= DONE;
                    end
                end

                DONE: begin
                    txid_q  <= txid_q + 8'd1;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx.start_sending = start_sending_q;
    assign tx.segment_num   = seg_q;
    assign tx.aux           = aux_q;
    assign tx.txid          = txid_q;
    assign oneframe_done    = oneframe_done_q;
    assign sched_active     = (state_q != IDLE);
    assign timeout_err      = timeout_err_q;
    assign frames_dropped   = frames_dropped_q;

endmodule
